// File: rtl/pll_lock_sequencer_if.sv
// ---------------------------------------------------------------------------
// pll_lock_sequencer_if
//
// Groups the control/status signals of the PLL lock sequencer.
//
//   pll_locked   PLL lock flag, asynchronous to refclk (driven by master)
//   restart      one-cycle synchronous restart request (driven by master)
//   pll_rst      PLL reset, active-high (driven by sequencer)
//   ready        PLL qualified locked (driven by sequencer)
//   fault        retries exhausted, sticky (driven by sequencer)
//   retry_count  failed attempts since reset/restart (driven by sequencer)
//   state        current sequencer state (driven by sequencer)
//
// Handshake: there is no valid/ready pairing here. restart is a level that
// is acted on in every cycle it is high; pll_locked is a free-running level
// that the sequencer synchronises before use. All sequencer outputs are
// registered and may be sampled at any time.
// ---------------------------------------------------------------------------
interface pll_lock_sequencer_if;
    logic       pll_locked;
    logic       restart;
    logic       pll_rst;
    logic       ready;
    logic       fault;
    logic [2:0] retry_count;
    logic [2:0] state;

    modport master (
        output pll_locked,
        output restart,
        input  pll_rst,
        input  ready,
        input  fault,
        input  retry_count,
        input  state
    );

    modport slave (
        input  pll_locked,
        input  restart,
        output pll_rst,
        output ready,
        output fault,
        output retry_count,
        output state
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// pll_lock_sequencer
//
// Reset and lock sequencer for the pixel-clock PLL. Runs on the PLL
// reference clock, pulses the PLL reset, synchronises and qualifies the
// PLL locked flag and presents a single clean ready. A lock timeout or a
// lock loss while running re-initialises the PLL; repeated failures end in
// a sticky FAULT state.
//
// Ports:
//   refclk   reference clock, the only clock of the block
//   rst_n    asynchronous active-low reset
//   bus      pll_lock_sequencer_if.slave (pll_locked, restart in;
//            pll_rst, ready, fault, retry_count, state out)
//
// Configuration macro: PLL_SEQ_AUTORETRY_EN
//   defined   : a failure retries the PLL reset until MAX_RETRIES failures
//               have been counted, then goes to FAULT.
//   undefined : any failure goes straight to FAULT; retry_count is tied 0.
//
// State encoding on bus.state: RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3,
// FAULT=4.
// ---------------------------------------------------------------------------
module pll_lock_sequencer #(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT = 65536,
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned MAX_RETRIES  = 7
) (
    input  logic                 refclk,
    input  logic                 rst_n,
    pll_lock_sequencer_if.slave  bus
);

    // Elaboration-time parameter sanity.
    if (RST_CYCLES < 2) begin : g_bad_rst_cycles
        $error("pll_lock_sequencer: RST_CYCLES must be at least 2");
    end
    if ((MAX_RETRIES < 1) || (MAX_RETRIES > 7)) begin : g_bad_max_retries
        $error("pll_lock_sequencer: MAX_RETRIES must be in 1..7");
    end

    // The shared counter must hold the largest terminal value; STABLE counts
    // up to LOCK_STABLE itself, hence the +1.
    localparam int unsigned MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAX_CYC = (MAX_AB > LOCK_STABLE) ? MAX_AB : LOCK_STABLE;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    // STABLE is entered on the first synchronised-locked cycle and then
    // needs LOCK_STABLE further qualified cycles, so it lasts LOCK_STABLE+1
    // cycles before RUN.
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_RUN    = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q;
    logic             lock_s_q;
    logic             fail;
    logic             pll_rst_q, ready_q, fault_q;

    // Two-flop synchroniser for the asynchronous lock flag.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync1_q  <= bus.pll_locked;
            lock_s_q <= sync1_q;
        end
    end

`ifdef PLL_SEQ_AUTORETRY_EN
    localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRIES);

    logic [2:0] retry_q, retry_d;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            retry_q <= 3'd0;
        end else begin
            retry_q <= retry_d;
        end
    end

    assign bus.retry_count = retry_q;
`else
    assign bus.retry_count = 3'd0;
`endif

    // State, counter and registered outputs. Outputs are decoded from the
    // next state so they line up with the registered state value.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RESET;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pll_rst_q <= (state_d == S_RESET) || (state_d == S_FAULT);
            ready_q   <= (state_d == S_RUN);
            fault_q   <= (state_d == S_FAULT);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fail    = 1'b0;
`ifdef PLL_SEQ_AUTORETRY_EN
        retry_d = retry_q;
`endif

        case (state_q)
            S_RESET: begin
                if (cnt_q == RST_LAST) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lock_s_q)                   state_d = S_STABLE;
                else if (cnt_q == TIMEOUT_LAST) fail    = 1'b1;
            end
            S_STABLE: begin
                // A drop here is a glitch, not a failure: re-arm the wait.
                if (!lock_s_q)                 state_d = S_WAIT;
                else if (cnt_q == STABLE_LAST) state_d = S_RUN;
            end
            S_RUN: begin
                if (!lock_s_q) fail = 1'b1;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase

        if (fail) begin
`ifdef PLL_SEQ_AUTORETRY_EN
            if (retry_q == RETRY_MAX) begin
                state_d = S_FAULT;
            end else begin
                retry_d = retry_q + 3'd1;
                state_d = S_RESET;
            end
`else
            state_d = S_FAULT;
`endif
        end

        // restart overrides any failure decided in the same cycle.
        if (bus.restart) begin
            state_d = S_RESET;
`ifdef PLL_SEQ_AUTORETRY_EN
            retry_d = 3'd0;
`endif
        end

        // Clear on every state entry, and on restart even when already in
        // RESET so the reset pulse is re-timed from scratch.
        if (bus.restart || (state_d != state_q)) begin
            cnt_d = '0;
        end else if ((state_q == S_RESET) || (state_q == S_WAIT) || (state_q == S_STABLE)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign bus.pll_rst = pll_rst_q;
    assign bus.ready   = ready_q;
    assign bus.fault   = fault_q;
    assign bus.state   = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_sequencer
//
// Directed bench for pll_lock_sequencer with RST_CYCLES=4, LOCK_TIMEOUT=32,
// LOCK_STABLE=8, MAX_RETRIES=2. Expected values are hand-derived cycle
// counts; expectations for the failure scenarios follow the
// PLL_SEQ_AUTORETRY_EN build option.
// ---------------------------------------------------------------------------
module tb_pll_lock_sequencer;

    localparam int RST_CYCLES   = 4;
    localparam int LOCK_TIMEOUT = 32;
    localparam int LOCK_STABLE  = 8;
    localparam int MAX_RETRIES  = 2;

`ifdef PLL_SEQ_AUTORETRY_EN
    localparam int FAULT_TICKS = 108;   // three 4+32 attempts
`else
    localparam int FAULT_TICKS = 36;    // one 4+32 attempt
`endif

    logic refclk = 1'b0;
    logic rst_n  = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    pll_lock_sequencer_if bus ();

    pll_lock_sequencer #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .LOCK_STABLE  (LOCK_STABLE),
        .MAX_RETRIES  (MAX_RETRIES)
    ) dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    // ---------------- clock / reset ----------------
    always #10 refclk = ~refclk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one (or n) clock edges and settle past the NBA updates.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    // Release of rst_n lands 1 time unit after an edge; the next tick is
    // the first active edge out of reset.
    task automatic apply_reset();
        bus.pll_locked = 1'b0;
        bus.restart    = 1'b0;
        rst_n          = 1'b0;
        tick(2);
        rst_n          = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.pll_locked = 1'b0;
        bus.restart    = 1'b0;
        rst_n          = 1'b0;
        tick(3);
        n_checks++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", bus.state); end
        n_checks++; if (bus.pll_rst !== 1'b1) begin n_fail++; $display("FAIL reset_pll_rst: got %b expected 1", bus.pll_rst); end
        n_checks++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", bus.ready); end
        n_checks++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b expected 0", bus.fault); end
        n_checks++; if (bus.retry_count !== 3'd0) begin n_fail++; $display("FAIL reset_retry: got %0d expected 0", bus.retry_count); end
    endtask

    task automatic test_clean_lock();
        int n;
        apply_reset();
        n = 0;
        while (bus.pll_rst === 1'b1 && n < 20) begin tick(); n++; end
        n_checks++; if (n != RST_CYCLES) begin n_fail++; $display("FAIL clean_rst_width: got %0d expected %0d", n, RST_CYCLES); end
        n_checks++; if (bus.state !== 3'd1) begin n_fail++; $display("FAIL clean_wait_state: got %0d expected 1", bus.state); end
        tick(10);
        bus.pll_locked = 1'b1;
        tick(3);
        n_checks++; if (bus.state !== 3'd2) begin n_fail++; $display("FAIL clean_stable_entry: got %0d expected 2", bus.state); end
        n_checks++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL clean_ready_early: got %b expected 0", bus.ready); end
        n = 3;
        while (bus.ready !== 1'b1 && n < 40) begin tick(); n++; end
        n_checks++; if (n != 12) begin n_fail++; $display("FAIL clean_ready_latency: got %0d expected 12", n); end
        n_checks++; if (bus.state !== 3'd3) begin n_fail++; $display("FAIL clean_run_state: got %0d expected 3", bus.state); end
        n_checks++; if (bus.retry_count !== 3'd0) begin n_fail++; $display("FAIL clean_retry: got %0d expected 0", bus.retry_count); end
    endtask

    task automatic test_stable_glitch();
        int  n;
        bit  rst_seen;
        apply_reset();
        tick(RST_CYCLES);
        bus.pll_locked = 1'b1;
        tick(3);
        n_checks++; if (bus.state !== 3'd2) begin n_fail++; $display("FAIL glitch_stable_entry: got %0d expected 2", bus.state); end
        tick(3);
        bus.pll_locked = 1'b0;
        rst_seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (bus.pll_rst === 1'b1) rst_seen = 1'b1;
        end
        n_checks++; if (bus.state !== 3'd2) begin n_fail++; $display("FAIL glitch_still_stable: got %0d expected 2", bus.state); end
        bus.pll_locked = 1'b1;
        tick();
        n = 1;
        n_checks++; if (bus.state !== 3'd1) begin n_fail++; $display("FAIL glitch_back_to_wait: got %0d expected 1", bus.state); end
        while (bus.ready !== 1'b1 && n < 40) begin
            if (bus.pll_rst === 1'b1) rst_seen = 1'b1;
            tick();
            n++;
        end
        n_checks++; if (n != 12) begin n_fail++; $display("FAIL glitch_ready_latency: got %0d expected 12", n); end
        n_checks++; if (rst_seen !== 1'b0) begin n_fail++; $display("FAIL glitch_no_pll_rst: got %b expected 0", rst_seen); end
        n_checks++; if (bus.retry_count !== 3'd0) begin n_fail++; $display("FAIL glitch_retry: got %0d expected 0", bus.retry_count); end
    endtask

    task automatic test_timeout_retry();
        bit retry_nonzero;
        apply_reset();
        retry_nonzero = 1'b0;
        for (int i = 1; i <= FAULT_TICKS + 12; i++) begin
            tick();
            if (bus.retry_count !== 3'd0) retry_nonzero = 1'b1;
            if (i == 35) begin
                n_checks++; if (bus.state !== 3'd1) begin n_fail++; $display("FAIL timeout_wait35: got %0d expected 1", bus.state); end
            end
`ifdef PLL_SEQ_AUTORETRY_EN
            if (i == 36) begin
                n_checks++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL timeout_reset36: got %0d expected 0", bus.state); end
                n_checks++; if (bus.retry_count !== 3'd1) begin n_fail++; $display("FAIL timeout_retry1: got %0d expected 1", bus.retry_count); end
                n_checks++; if (bus.pll_rst !== 1'b1) begin n_fail++; $display("FAIL timeout_rst36: got %b expected 1", bus.pll_rst); end
            end
            if (i == 39) begin
                n_checks++; if (bus.pll_rst !== 1'b1) begin n_fail++; $display("FAIL timeout_rst39: got %b expected 1", bus.pll_rst); end
            end
            if (i == 40) begin
                n_checks++; if (bus.pll_rst !== 1'b0) begin n_fail++; $display("FAIL timeout_rst40: got %b expected 0", bus.pll_rst); end
            end
            if (i == 72) begin
                n_checks++; if (bus.retry_count !== 3'd2) begin n_fail++; $display("FAIL timeout_retry2: got %0d expected 2", bus.retry_count); end
                n_checks++; if (bus.pll_rst !== 1'b1) begin n_fail++; $display("FAIL timeout_rst72: got %b expected 1", bus.pll_rst); end
            end
            if (i == 76) begin
                n_checks++; if (bus.pll_rst !== 1'b0) begin n_fail++; $display("FAIL timeout_rst76: got %b expected 0", bus.pll_rst); end
            end
            if (i == 107) begin
                n_checks++; if (bus.state !== 3'd1) begin n_fail++; $display("FAIL timeout_wait107: got %0d expected 1", bus.state); end
            end
`endif
            if (i == FAULT_TICKS) begin
                n_checks++; if (bus.state !== 3'd4) begin n_fail++; $display("FAIL timeout_fault_state: got %0d expected 4", bus.state); end
                n_checks++; if (bus.fault !== 1'b1) begin n_fail++; $display("FAIL timeout_fault_flag: got %b expected 1", bus.fault); end
            end
            if (i == FAULT_TICKS + 12) begin
                n_checks++; if (bus.pll_rst !== 1'b1) begin n_fail++; $display("FAIL timeout_fault_rst_held: got %b expected 1", bus.pll_rst); end
                n_checks++; if (bus.state !== 3'd4) begin n_fail++; $display("FAIL timeout_fault_sticky: got %0d expected 4", bus.state); end
`ifdef PLL_SEQ_AUTORETRY_EN
                n_checks++; if (bus.retry_count !== 3'd2) begin n_fail++; $display("FAIL timeout_retry_sat: got %0d expected 2", bus.retry_count); end
`else
                n_checks++; if (retry_nonzero !== 1'b0) begin n_fail++; $display("FAIL timeout_retry_const0: got %b expected 0", retry_nonzero); end
`endif
            end
        end
    endtask

    task automatic test_run_lock_loss();
        int n;
        apply_reset();
        tick(RST_CYCLES);
        bus.pll_locked = 1'b1;
        n = 0;
        while (bus.ready !== 1'b1 && n < 40) begin tick(); n++; end
        n_checks++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL loss_reach_run: got %b expected 1", bus.ready); end
        bus.pll_locked = 1'b0;
        tick(2);
        n_checks++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL loss_ready_hold: got %b expected 1", bus.ready); end
        tick();
        n_checks++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL loss_ready_fall: got %b expected 0", bus.ready); end
        n_checks++; if (bus.pll_rst !== 1'b1) begin n_fail++; $display("FAIL loss_pll_rst_rise: got %b expected 1", bus.pll_rst); end
`ifdef PLL_SEQ_AUTORETRY_EN
        n_checks++; if (bus.retry_count !== 3'd1) begin n_fail++; $display("FAIL loss_retry: got %0d expected 1", bus.retry_count); end
        n_checks++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL loss_state: got %0d expected 0", bus.state); end
        bus.pll_locked = 1'b1;
        n = 0;
        while (bus.ready !== 1'b1 && n < 60) begin tick(); n++; end
        n_checks++; if (bus.state !== 3'd3) begin n_fail++; $display("FAIL loss_relock_run: got %0d expected 3", bus.state); end
        n_checks++; if (bus.retry_count !== 3'd1) begin n_fail++; $display("FAIL loss_relock_retry: got %0d expected 1", bus.retry_count); end
`else
        n_checks++; if (bus.state !== 3'd4) begin n_fail++; $display("FAIL loss_state: got %0d expected 4", bus.state); end
        n_checks++; if (bus.fault !== 1'b1) begin n_fail++; $display("FAIL loss_fault: got %b expected 1", bus.fault); end
        n_checks++; if (bus.retry_count !== 3'd0) begin n_fail++; $display("FAIL loss_retry: got %0d expected 0", bus.retry_count); end
`endif
    endtask

    task automatic test_restart();
        // restart coinciding with a WAIT_LOCK timeout
        apply_reset();
        tick(35);
        n_checks++; if (bus.state !== 3'd1) begin n_fail++; $display("FAIL rs_pre_timeout: got %0d expected 1", bus.state); end
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
        n_checks++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL rs_timeout_state: got %0d expected 0", bus.state); end
        n_checks++; if (bus.retry_count !== 3'd0) begin n_fail++; $display("FAIL rs_timeout_retry: got %0d expected 0", bus.retry_count); end
        n_checks++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL rs_timeout_fault: got %b expected 0", bus.fault); end
        n_checks++; if (bus.pll_rst !== 1'b1) begin n_fail++; $display("FAIL rs_timeout_rst: got %b expected 1", bus.pll_rst); end

        // restart while in RESET re-times the reset pulse
        apply_reset();
        tick(2);
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
        tick(3);
        n_checks++; if (bus.pll_rst !== 1'b1) begin n_fail++; $display("FAIL rs_in_reset_hold: got %b expected 1", bus.pll_rst); end
        tick();
        n_checks++; if (bus.pll_rst !== 1'b0) begin n_fail++; $display("FAIL rs_in_reset_release: got %b expected 0", bus.pll_rst); end

        // restart from FAULT
        apply_reset();
        tick(FAULT_TICKS + 2);
        n_checks++; if (bus.state !== 3'd4) begin n_fail++; $display("FAIL rs_reach_fault: got %0d expected 4", bus.state); end
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
        n_checks++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL rs_fault_state: got %0d expected 0", bus.state); end
        n_checks++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL rs_fault_flag: got %b expected 0", bus.fault); end
        n_checks++; if (bus.retry_count !== 3'd0) begin n_fail++; $display("FAIL rs_fault_retry: got %0d expected 0", bus.retry_count); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        tick(RST_CYCLES);
        bus.pll_locked = 1'b1;
        tick(5);
        n_checks++; if (bus.state !== 3'd2) begin n_fail++; $display("FAIL arst_in_stable: got %0d expected 2", bus.state); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL arst_state: got %0d expected 0", bus.state); end
        n_checks++; if (bus.pll_rst !== 1'b1) begin n_fail++; $display("FAIL arst_pll_rst: got %b expected 1", bus.pll_rst); end
        n_checks++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL arst_ready: got %b expected 0", bus.ready); end
        n_checks++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL arst_fault: got %b expected 0", bus.fault); end
        n_checks++; if (bus.retry_count !== 3'd0) begin n_fail++; $display("FAIL arst_retry: got %0d expected 0", bus.retry_count); end
        tick();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        bus.pll_locked = 1'b0;
        bus.restart    = 1'b0;
        test_reset();
        test_clean_lock();
        test_stable_glitch();
        test_timeout_retry();
        test_run_lock_loss();
        test_restart();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
